pd_debug_cnt_bank: RTL and testbench

Downstream of the three-stage PD debug matcher chain: it consumes the matcher's per-PD increment strobes, byte-count amount and capture pulses, and accumulates them into saturating software-visible counters and capture registers. A single-outstanding CIF read port returns counter, capture and status words, with optional clear-on-read. The 48-bit byte counters are read atomically through a low-word-snapshot / high-word-shadow pair.

---
 rtl/pd_debug_cnt_pkg.sv | 34 +++
 rtl/pd_debug_sat_cnt.sv | 57 +++++
 rtl/pd_debug_cnt_bank.sv | 186 ++++++++++++++++++
 tb/tb_pd_debug_cnt_bank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pd_debug_cnt_pkg.sv
// Shared definitions for the PD debug counter bank: read address map,
// status word bit positions and counter ordering for saturation flags.
package pd_debug_cnt_pkg;

  typedef enum logic [3:0] {
    ADDR_F1_CNT     = 4'd0,
    ADDR_F2_CNT     = 4'd1,
    ADDR_CAP_CNT    = 4'd2,
    ADDR_TOTAL_CNT  = 4'd3,
    ADDR_F1_BYTE_LO = 4'd4,
    ADDR_F1_BYTE_HI = 4'd5,
    ADDR_F2_BYTE_LO = 4'd6,
    ADDR_F2_BYTE_HI = 4'd7,
    ADDR_CAP1       = 4'd8,
    ADDR_CAP2       = 4'd9,
    ADDR_STATUS     = 4'd10
  } addr_e;

  localparam int STAT_CAP1_VALID = 0;
  localparam int STAT_CAP2_VALID = 1;
  localparam int STAT_SAT_LSB    = 2;

  typedef enum logic [2:0] {
    CNT_F1      = 3'd0,
    CNT_F2      = 3'd1,
    CNT_CAP     = 3'd2,
    CNT_TOTAL   = 3'd3,
    CNT_F1_BYTE = 3'd4,
    CNT_F2_BYTE = 3'd5
  } cnt_idx_e;

  localparam int NUM_CNT = 6;

endpackage

// File: rtl/pd_debug_sat_cnt.sv
// Saturating accumulator: an optional clear is applied first, then the
// increment is added, so a clearing read never loses a same-cycle event.
module pd_debug_sat_cnt #(
  parameter int W  = 32,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_all_i,
  input  logic          clr_cnt_i,
  input  logic          clr_sat_i,
  input  logic          inc_i,
  input  logic [AW-1:0] amt_i,
  output logic [W-1:0]  cnt_o,
  output logic          sat_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;
  logic [W-1:0] base;
  logic [W:0]   sum;

  // Clear-then-add with one extra carry bit to detect overflow; clr_all wins over everything
  always_comb begin
    base  = clr_cnt_i ? '0 : cnt_q;
    sum   = {1'b0, base} + {{(W + 1 - AW){1'b0}}, amt_i};
    cnt_d = base;
    sat_d = clr_sat_i ? 1'b0 : sat_q;
    if (inc_i) begin
      if (sum[W]) begin
        cnt_d = '1;
        sat_d = 1'b1;
      end else begin
        cnt_d = sum[W-1:0];
      end
    end
    if (clr_all_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  // Counter and sticky saturation state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/pd_debug_cnt_bank.sv
// PD debug counter bank: saturating event/byte counters, capture registers
// and a single-outstanding read port with optional clear-on-read.
module pd_debug_cnt_bank
  import pd_debug_cnt_pkg::*;
#(
  parameter int CNT_WIDTH         = 32,
  parameter int BYTE_CNT_WIDTH    = 48,
  parameter int PACKET_SIZE_WIDTH = 12,
  parameter int CAPTURE_LAT       = 1,
  parameter int CAPTURE_FIRST     = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field1,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field2,
  input  logic [31:0]                  dbg2cif_c_debug_pd_out,
  input  logic                         cif2dbg_rd_req,
  input  logic [3:0]                   cif2dbg_rd_addr,
  input  logic                         cif2dbg_rd_clr,
  input  logic                         cif2dbg_clr_all,
  output logic                         dbg2cif_rd_ack,
  output logic [31:0]                  dbg2cif_rd_data
);

  localparam int SHW = BYTE_CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0]      f1Cnt, f2Cnt, capCnt, totalCnt;
  logic [BYTE_CNT_WIDTH-1:0] f1Byte, f2Byte;
  logic [NUM_CNT-1:0]        sat;
  logic                      rdClr, clrSat;
  logic [SHW-1:0]            shadow1_q, shadow1_d, shadow2_q, shadow2_d;
  logic [31:0]               cap1_q, cap1_d, cap2_q, cap2_d;
  logic                      cap1Valid_q, cap1Valid_d, cap2Valid_q, cap2Valid_d;
  logic                      cap1Dly_q, cap1Dly_d, cap2Dly_q, cap2Dly_d;
  logic                      cap1Fire, cap2Fire, clrCap1, clrCap2;
  logic                      rdAck_q, rdAck_d;
  logic [31:0]               rdData_q, rdData_d, rdMux, statusWord;

  assign rdClr  = cif2dbg_rd_req & cif2dbg_rd_clr;
  assign clrSat = rdClr && (cif2dbg_rd_addr == ADDR_STATUS);

  pd_debug_sat_cnt #(.W(CNT_WIDTH), .AW(1)) u_cntF1 (
    .clk(clk), .rstn(rstn), .clr_all_i(cif2dbg_clr_all),
    .clr_cnt_i(rdClr && (cif2dbg_rd_addr == ADDR_F1_CNT)), .clr_sat_i(clrSat),
    .inc_i(dbg2cif_e_debug_pd_field1_cnt_inc), .amt_i(1'b1),
    .cnt_o(f1Cnt), .sat_o(sat[CNT_F1]));

  pd_debug_sat_cnt #(.W(CNT_WIDTH), .AW(1)) u_cntF2 (
    .clk(clk), .rstn(rstn), .clr_all_i(cif2dbg_clr_all),
    .clr_cnt_i(rdClr && (cif2dbg_rd_addr == ADDR_F2_CNT)), .clr_sat_i(clrSat),
    .inc_i(dbg2cif_e_debug_pd_field2_cnt_inc), .amt_i(1'b1),
    .cnt_o(f2Cnt), .sat_o(sat[CNT_F2]));

  pd_debug_sat_cnt #(.W(CNT_WIDTH), .AW(1)) u_cntCap (
    .clk(clk), .rstn(rstn), .clr_all_i(cif2dbg_clr_all),
    .clr_cnt_i(rdClr && (cif2dbg_rd_addr == ADDR_CAP_CNT)), .clr_sat_i(clrSat),
    .inc_i(dbg2cif_e_debug_pd_capture_match_cnt_inc), .amt_i(1'b1),
    .cnt_o(capCnt), .sat_o(sat[CNT_CAP]));

  pd_debug_sat_cnt #(.W(CNT_WIDTH), .AW(1)) u_cntTotal (
    .clk(clk), .rstn(rstn), .clr_all_i(cif2dbg_clr_all),
    .clr_cnt_i(rdClr && (cif2dbg_rd_addr == ADDR_TOTAL_CNT)), .clr_sat_i(clrSat),
    .inc_i(dbg2cif_e_debug_pd_total_pd_cnt_inc), .amt_i(1'b1),
    .cnt_o(totalCnt), .sat_o(sat[CNT_TOTAL]));

  pd_debug_sat_cnt #(.W(BYTE_CNT_WIDTH), .AW(PACKET_SIZE_WIDTH)) u_cntF1Byte (
    .clk(clk), .rstn(rstn), .clr_all_i(cif2dbg_clr_all),
    .clr_cnt_i(rdClr && (cif2dbg_rd_addr == ADDR_F1_BYTE_LO)), .clr_sat_i(clrSat),
    .inc_i(dbg2cif_e_debug_pd_field1_byte_cnt_inc),
    .amt_i(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
    .cnt_o(f1Byte), .sat_o(sat[CNT_F1_BYTE]));

  pd_debug_sat_cnt #(.W(BYTE_CNT_WIDTH), .AW(PACKET_SIZE_WIDTH)) u_cntF2Byte (
    .clk(clk), .rstn(rstn), .clr_all_i(cif2dbg_clr_all),
    .clr_cnt_i(rdClr && (cif2dbg_rd_addr == ADDR_F2_BYTE_LO)), .clr_sat_i(clrSat),
    .inc_i(dbg2cif_e_debug_pd_field2_byte_cnt_inc),
    .amt_i(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
    .cnt_o(f2Byte), .sat_o(sat[CNT_F2_BYTE]));

  // Status word: capture valids in the low bits, saturation flags above in counter order
  always_comb begin
    statusWord = '0;
    statusWord[STAT_CAP1_VALID] = cap1Valid_q;
    statusWord[STAT_CAP2_VALID] = cap2Valid_q;
    statusWord[STAT_SAT_LSB +: NUM_CNT] = sat;
  end

  // Read data selection from pre-edge state
  always_comb begin
    rdMux = '0;
    case (cif2dbg_rd_addr)
      ADDR_F1_CNT:     rdMux = 32'(f1Cnt);
      ADDR_F2_CNT:     rdMux = 32'(f2Cnt);
      ADDR_CAP_CNT:    rdMux = 32'(capCnt);
      ADDR_TOTAL_CNT:  rdMux = 32'(totalCnt);
      ADDR_F1_BYTE_LO: rdMux = f1Byte[31:0];
      ADDR_F1_BYTE_HI: rdMux = 32'(shadow1_q);
      ADDR_F2_BYTE_LO: rdMux = f2Byte[31:0];
      ADDR_F2_BYTE_HI: rdMux = 32'(shadow2_q);
      ADDR_CAP1:       rdMux = cap1_q;
      ADDR_CAP2:       rdMux = cap2_q;
      ADDR_STATUS:     rdMux = statusWord;
      default:         rdMux = '0;
    endcase
  end

  // Next-state for shadows, capture pipe and capture registers; a capture beats a same-cycle valid clear
  always_comb begin
    shadow1_d = shadow1_q;
    shadow2_d = shadow2_q;
    if (cif2dbg_rd_req && (cif2dbg_rd_addr == ADDR_F1_BYTE_LO)) shadow1_d = f1Byte[BYTE_CNT_WIDTH-1:32];
    if (cif2dbg_rd_req && (cif2dbg_rd_addr == ADDR_F2_BYTE_LO)) shadow2_d = f2Byte[BYTE_CNT_WIDTH-1:32];

    cap1Dly_d = dbg2cif_e_debug_pd_capture_match_field1;
    cap2Dly_d = dbg2cif_e_debug_pd_capture_match_field2;
    cap1Fire  = (CAPTURE_LAT == 0) ? dbg2cif_e_debug_pd_capture_match_field1 : cap1Dly_q;
    cap2Fire  = (CAPTURE_LAT == 0) ? dbg2cif_e_debug_pd_capture_match_field2 : cap2Dly_q;
    clrCap1   = rdClr && ((cif2dbg_rd_addr == ADDR_CAP1) || (cif2dbg_rd_addr == ADDR_STATUS));
    clrCap2   = rdClr && ((cif2dbg_rd_addr == ADDR_CAP2) || (cif2dbg_rd_addr == ADDR_STATUS));

    cap1_d      = cap1_q;
    cap2_d      = cap2_q;
    cap1Valid_d = clrCap1 ? 1'b0 : cap1Valid_q;
    cap2Valid_d = clrCap2 ? 1'b0 : cap2Valid_q;
    if (cap1Fire && ((CAPTURE_FIRST == 0) || !cap1Valid_d)) begin
      cap1_d      = dbg2cif_c_debug_pd_out;
      cap1Valid_d = 1'b1;
    end
    if (cap2Fire && ((CAPTURE_FIRST == 0) || !cap2Valid_d)) begin
      cap2_d      = dbg2cif_c_debug_pd_out;
      cap2Valid_d = 1'b1;
    end

    if (cif2dbg_clr_all) begin
      shadow1_d   = '0;
      shadow2_d   = '0;
      cap1Dly_d   = 1'b0;
      cap2Dly_d   = 1'b0;
      cap1_d      = '0;
      cap2_d      = '0;
      cap1Valid_d = 1'b0;
      cap2Valid_d = 1'b0;
    end

    rdAck_d  = cif2dbg_rd_req;
    rdData_d = cif2dbg_rd_req ? rdMux : rdData_q;
  end

  // State registers for shadows, captures and the read response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow1_q   <= '0;
      shadow2_q   <= '0;
      cap1Dly_q   <= 1'b0;
      cap2Dly_q   <= 1'b0;
      cap1_q      <= '0;
      cap2_q      <= '0;
      cap1Valid_q <= 1'b0;
      cap2Valid_q <= 1'b0;
      rdAck_q     <= 1'b0;
      rdData_q    <= '0;
    end else begin
      shadow1_q   <= shadow1_d;
      shadow2_q   <= shadow2_d;
      cap1Dly_q   <= cap1Dly_d;
      cap2Dly_q   <= cap2Dly_d;
      cap1_q      <= cap1_d;
      cap2_q      <= cap2_d;
      cap1Valid_q <= cap1Valid_d;
      cap2Valid_q <= cap2Valid_d;
      rdAck_q     <= rdAck_d;
      rdData_q    <= rdData_d;
    end
  end

  assign dbg2cif_rd_ack  = rdAck_q;
  assign dbg2cif_rd_data = rdData_q;

endmodule

// File: tb/tb_pd_debug_cnt_bank.sv
// Directed self-checking bench for pd_debug_cnt_bank (default parameters).
module tb_pd_debug_cnt_bank;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        f1Inc = 0, f2Inc = 0, capInc = 0, totalInc = 0;
  logic        f1ByteInc = 0, f2ByteInc = 0;
  logic [11:0] amount = '0;
  logic        cap1 = 0, cap2 = 0;
  logic [31:0] pdOut = '0;
  logic        rdReq = 0, rdClr = 0, clrAll = 0;
  logic [3:0]  rdAddr = '0;
  logic        rdAck;
  logic [31:0] rdData;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pd_debug_cnt_bank dut (
    .clk(clk),
    .rstn(rstn),
    .dbg2cif_e_debug_pd_field1_cnt_inc(f1Inc),
    .dbg2cif_e_debug_pd_field2_cnt_inc(f2Inc),
    .dbg2cif_e_debug_pd_capture_match_cnt_inc(capInc),
    .dbg2cif_e_debug_pd_total_pd_cnt_inc(totalInc),
    .dbg2cif_e_debug_pd_field1_byte_cnt_inc(f1ByteInc),
    .dbg2cif_e_debug_pd_field2_byte_cnt_inc(f2ByteInc),
    .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount(amount),
    .dbg2cif_e_debug_pd_capture_match_field1(cap1),
    .dbg2cif_e_debug_pd_capture_match_field2(cap2),
    .dbg2cif_c_debug_pd_out(pdOut),
    .cif2dbg_rd_req(rdReq),
    .cif2dbg_rd_addr(rdAddr),
    .cif2dbg_rd_clr(rdClr),
    .cif2dbg_clr_all(clrAll),
    .dbg2cif_rd_ack(rdAck),
    .dbg2cif_rd_data(rdData)
  );

  // Single read transaction; returns the ack and data sampled on the next falling edge
  task automatic doRead(input logic [3:0] a, input logic c, output logic [31:0] d, output logic ack);
    @(negedge clk); rdReq = 1; rdAddr = a; rdClr = c;
    @(negedge clk); rdReq = 0; rdClr = 0; rdAddr = '0; ack = rdAck; d = rdData;
  endtask

  // Capture pulse with the PD word presented one cycle later
  task automatic capPulse(input logic c1, input logic c2, input logic [31:0] word);
    @(negedge clk); cap1 = c1; cap2 = c2; pdOut = '0;
    @(negedge clk); cap1 = 0; cap2 = 0; pdOut = word;
    @(negedge clk); pdOut = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a;
    repeat (3) @(negedge clk);
    checks++; if (rdAck !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", rdAck); end
    checks++; if (rdData !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", rdData); end
    rstn = 1;
    for (int i = 0; i <= 11; i++) begin
      doRead(4'(i), 1'b0, d, a);
      checks++; if (a !== 1'b1 || d !== 32'h0) begin failures++; $display("[TB] FAIL reset_read addr %0d: got ack=%b data=%h expected ack=1 data=0", i, a, d); end
    end
  endtask

  task automatic test_total_cnt();
    logic [31:0] d; logic a;
    @(negedge clk); totalInc = 1;
    repeat (5) @(negedge clk);
    totalInc = 0;
    doRead(4'd3, 1'b0, d, a);
    checks++; if (a !== 1'b1 || d !== 32'd5) begin failures++; $display("[TB] FAIL total_read: got ack=%b data=%h expected ack=1 data=5", a, d); end
    repeat (3) @(negedge clk);
    checks++; if (rdAck !== 1'b0 || rdData !== 32'd5) begin failures++; $display("[TB] FAIL data_hold: got ack=%b data=%h expected ack=0 data=5", rdAck, rdData); end
    doRead(4'd3, 1'b1, d, a);
    checks++; if (d !== 32'd5) begin failures++; $display("[TB] FAIL total_clr_read: got %h expected 5", d); end
    doRead(4'd3, 1'b0, d, a);
    checks++; if (d !== 32'd0) begin failures++; $display("[TB] FAIL total_after_clr: got %h expected 0", d); end
  endtask

  task automatic test_byte_cnt();
    logic [31:0] d; logic a;
    @(negedge clk); f1ByteInc = 1; amount = 12'hFFF;
    @(negedge clk); amount = 12'h001;
    @(negedge clk); f1ByteInc = 0; amount = '0;
    doRead(4'd4, 1'b0, d, a);
    checks++; if (d !== 32'h0000_1000) begin failures++; $display("[TB] FAIL byte1_lo: got %h expected 00001000", d); end
    doRead(4'd5, 1'b0, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL byte1_hi: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic a;
    @(negedge clk); force dut.u_cntF1Byte.cnt_q = 48'h0002_FFFF_FFF0;
    @(negedge clk); release dut.u_cntF1Byte.cnt_q;
    rdReq = 1; rdAddr = 4'd4; f1ByteInc = 1; amount = 12'h020;
    @(negedge clk);
    checks++; if (rdAck !== 1'b1 || rdData !== 32'hFFFF_FFF0) begin failures++; $display("[TB] FAIL b2b_lo: got ack=%b data=%h expected ack=1 data=fffffff0", rdAck, rdData); end
    rdAddr = 4'd5; f1ByteInc = 0; amount = '0;
    @(negedge clk);
    checks++; if (rdAck !== 1'b1 || rdData !== 32'h2) begin failures++; $display("[TB] FAIL b2b_shadow: got ack=%b data=%h expected ack=1 data=2", rdAck, rdData); end
    rdReq = 0; rdAddr = '0;
    doRead(4'd4, 1'b0, d, a);
    checks++; if (d !== 32'h0000_0010) begin failures++; $display("[TB] FAIL b2b_lo2: got %h expected 00000010", d); end
    doRead(4'd5, 1'b0, d, a);
    checks++; if (d !== 32'h3) begin failures++; $display("[TB] FAIL b2b_hi2: got %h expected 3", d); end
    doRead(4'd4, 1'b1, d, a);
    checks++; if (d !== 32'h0000_0010) begin failures++; $display("[TB] FAIL byte_clr_read: got %h expected 00000010", d); end
    doRead(4'd5, 1'b0, d, a);
    checks++; if (d !== 32'h3) begin failures++; $display("[TB] FAIL byte_clr_shadow: got %h expected 3", d); end
    doRead(4'd4, 1'b0, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL byte_after_clr: got %h expected 0", d); end
  endtask

  task automatic test_saturation();
    logic [31:0] d; logic a;
    @(negedge clk); force dut.u_cntF2.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk); release dut.u_cntF2.cnt_q;
    f2Inc = 1;
    repeat (3) @(negedge clk);
    f2Inc = 0;
    doRead(4'd1, 1'b0, d, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL f2_sat_value: got %h expected ffffffff", d); end
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h0000_0008) begin failures++; $display("[TB] FAIL status_sat_f2: got %h expected 00000008", d); end
    doRead(4'd10, 1'b1, d, a);
    checks++; if (d !== 32'h0000_0008) begin failures++; $display("[TB] FAIL status_clr_read: got %h expected 00000008", d); end
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL status_after_clr: got %h expected 0", d); end
    doRead(4'd1, 1'b0, d, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL f2_kept: got %h expected ffffffff", d); end
    @(negedge clk); force dut.u_cntF2Byte.cnt_q = 48'hFFFF_FFFF_F000;
    @(negedge clk); release dut.u_cntF2Byte.cnt_q;
    f2ByteInc = 1; amount = 12'hFFF;
    @(negedge clk); f2ByteInc = 0; amount = '0;
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL byte_exact_max_no_sat: got %h expected 0", d); end
    @(negedge clk); f2ByteInc = 1; amount = 12'h001;
    @(negedge clk); f2ByteInc = 0; amount = '0;
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h0000_0080) begin failures++; $display("[TB] FAIL status_sat_f2byte: got %h expected 00000080", d); end
    doRead(4'd6, 1'b1, d, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL f2byte_lo_sat: got %h expected ffffffff", d); end
    doRead(4'd7, 1'b0, d, a);
    checks++; if (d !== 32'h0000_FFFF) begin failures++; $display("[TB] FAIL f2byte_hi_sat: got %h expected 0000ffff", d); end
    doRead(4'd10, 1'b1, d, a);
  endtask

  task automatic test_clear_collision();
    logic [31:0] d; logic a;
    @(negedge clk); f1Inc = 1;
    repeat (3) @(negedge clk);
    rdReq = 1; rdAddr = 4'd0; rdClr = 1;
    @(negedge clk);
    checks++; if (rdAck !== 1'b1 || rdData !== 32'd3) begin failures++; $display("[TB] FAIL clr_collision_read: got ack=%b data=%h expected ack=1 data=3", rdAck, rdData); end
    rdReq = 0; rdClr = 0; f1Inc = 0;
    doRead(4'd0, 1'b0, d, a);
    checks++; if (d !== 32'd1) begin failures++; $display("[TB] FAIL clr_collision_after: got %h expected 1", d); end
  endtask

  task automatic test_capture();
    logic [31:0] d; logic a;
    capPulse(1'b1, 1'b0, 32'hA5A5_0001);
    capPulse(1'b1, 1'b0, 32'hA5A5_0002);
    doRead(4'd8, 1'b0, d, a);
    checks++; if (d !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL cap1_first: got %h expected a5a50001", d); end
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h1) begin failures++; $display("[TB] FAIL cap1_valid: got %h expected 1", d); end
    doRead(4'd8, 1'b1, d, a);
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL cap1_valid_cleared: got %h expected 0", d); end
    capPulse(1'b1, 1'b0, 32'hA5A5_0003);
    doRead(4'd8, 1'b0, d, a);
    checks++; if (d !== 32'hA5A5_0003) begin failures++; $display("[TB] FAIL cap1_recapture: got %h expected a5a50003", d); end
    capPulse(1'b1, 1'b1, 32'hBEEF_0042);
    doRead(4'd9, 1'b0, d, a);
    checks++; if (d !== 32'hBEEF_0042) begin failures++; $display("[TB] FAIL cap2_word: got %h expected beef0042", d); end
    doRead(4'd8, 1'b0, d, a);
    checks++; if (d !== 32'hA5A5_0003) begin failures++; $display("[TB] FAIL cap1_kept: got %h expected a5a50003", d); end
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h3) begin failures++; $display("[TB] FAIL both_valid: got %h expected 3", d); end
    @(negedge clk); cap1 = 1;
    @(negedge clk); cap1 = 0; pdOut = 32'h0000_0077; rdReq = 1; rdAddr = 4'd8; rdClr = 1;
    @(negedge clk);
    checks++; if (rdData !== 32'hA5A5_0003) begin failures++; $display("[TB] FAIL cap_vs_clr_read: got %h expected a5a50003", rdData); end
    rdReq = 0; rdClr = 0; rdAddr = '0; pdOut = '0;
    doRead(4'd8, 1'b0, d, a);
    checks++; if (d !== 32'h0000_0077) begin failures++; $display("[TB] FAIL cap_wins_word: got %h expected 00000077", d); end
    doRead(4'd10, 1'b0, d, a);
    checks++; if (d !== 32'h3) begin failures++; $display("[TB] FAIL cap_wins_valid: got %h expected 3", d); end
  endtask

  task automatic test_clr_all();
    logic [31:0] d; logic a;
    @(negedge clk);
    clrAll = 1; f1Inc = 1; f2Inc = 1; capInc = 1; totalInc = 1;
    f1ByteInc = 1; f2ByteInc = 1; amount = 12'h005; cap1 = 1; cap2 = 1;
    rdReq = 1; rdAddr = 4'd3;
    @(negedge clk);
    checks++; if (rdAck !== 1'b1) begin failures++; $display("[TB] FAIL clr_all_ack: got %b expected 1", rdAck); end
    clrAll = 0; f1Inc = 0; f2Inc = 0; capInc = 0; totalInc = 0;
    f1ByteInc = 0; f2ByteInc = 0; amount = '0; cap1 = 0; cap2 = 0;
    rdReq = 0; rdAddr = '0; pdOut = 32'hDEAD_BEEF;
    @(negedge clk); pdOut = '0;
    for (int i = 0; i <= 10; i++) begin
      doRead(4'(i), 1'b0, d, a);
      checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL clr_all_state addr %0d: got %h expected 0", i, d); end
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); f2Inc = 1;
    @(negedge clk); f2Inc = 0; rdReq = 1; rdAddr = 4'd1;
    @(negedge clk); rdReq = 0; rdAddr = '0;
    checks++; if (rdAck !== 1'b1 || rdData !== 32'd1) begin failures++; $display("[TB] FAIL pre_reset_read: got ack=%b data=%h expected ack=1 data=1", rdAck, rdData); end
    #1 rstn = 0;
    #1;
    checks++; if (rdAck !== 1'b0 || rdData !== 32'h0) begin failures++; $display("[TB] FAIL reset_drops_ack: got ack=%b data=%h expected ack=0 data=0", rdAck, rdData); end
    @(negedge clk); rstn = 1;
  endtask

  initial begin
    test_reset();
    test_total_cnt();
    test_byte_cnt();
    test_back_to_back();
    test_saturation();
    test_clear_collision();
    test_capture();
    test_clr_all();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
